// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared constants and types for the sequential divider.
//   RegBus / ZeroWord      - architectural word width and the all-zero word
//   DivResultReady/NotReady - ready flag encodings
//   DivStart / DivStop     - start request encodings
//   div_state_e            - divider sequencer states (2-bit encoding)
package div_seq_pkg;

  localparam int                RegBus   = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// div_seq: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
//   Operands are latched on an accepted start; one quotient bit is produced per
//   cycle, and the pipeline is held via stall_req_o until the result is ready.
//   result_o = {remainder, quotient}: HI = [63:32], LO = [31:0].
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   signed_div_i 1 = DIV (signed), 0 = DIVU
//   opdata1_i    dividend (rs)
//   opdata2_i    divisor (rt)
//   start_i      division request; held high until the result is consumed
//   annul_i      abort an in-flight division (flush / exception)
//   result_o     {remainder, quotient}
//   ready_o      result valid
//   stall_req_o  combinational stall request to pipeline control
//
// Build option:
//   DIV_SIGNED_EN  when defined, signed_div_i is honoured (abs / negate logic
//                  present); when undefined every division is unsigned.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = RegBus,  // only 32 is supported
  parameter int CNT_W  = 6        // must be able to hold DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stall_req_o
);

  div_state_e state, state_d;

  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [2*DATA_W:0]   work, work_d;       // {partial remainder, dividend/quotient, spare}
  logic [DATA_W-1:0]   divisor, divisor_d; // |op2|, latched at start
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  logic                accept;             // start taken with a nonzero divisor
  logic [DATA_W:0]     trial;              // 33-bit trial subtraction
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

  assign stall_req_o = start_i & ~annul_i & ~ready_o;

  assign accept = (state == DivFree) && (start_i == DivStart) && !annul_i &&
                  (opdata2_i != ZeroWord);

  // The candidate remainder is the upper window after the pending one-bit
  // shift, so it already includes the next dividend bit.
  assign trial    = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
  assign quot_raw = work[DATA_W-1:0];
  assign rem_raw  = work[2*DATA_W:DATA_W+1];

`ifdef DIV_SIGNED_EN
  logic op1_neg, op2_neg;
  logic neg_quot, neg_rem;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (accept) begin
      neg_quot <= op1_neg ^ op2_neg;
      neg_rem  <= op1_neg;          // remainder follows the dividend's sign
    end
  end

  assign quot_fix = neg_quot ? -quot_raw : quot_raw;
  assign rem_fix  = neg_rem  ? -rem_raw  : rem_raw;
`else
  logic unused_signed;

  assign unused_signed = signed_div_i;
  assign op1_abs       = opdata1_i;
  assign op2_abs       = opdata2_i;
  assign quot_fix      = quot_raw;
  assign rem_fix       = rem_raw;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    work_d    = work;
    divisor_d = divisor;
    result_d  = result_o;
    ready_d   = ready_o;

    unique case (state)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if ((start_i == DivStart) && !annul_i) begin
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            work_d    = {ZeroWord, op1_abs, 1'b0};
            divisor_d = op2_abs;
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt != CNT_W'(DATA_W)) begin
          if (trial[DATA_W]) begin
            work_d = {work[2*DATA_W-1:0], 1'b0};
          end else begin
            work_d = {trial[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt + CNT_W'(1);
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end

      DivEnd: begin
        // annul_i is ignored here; only dropping start releases the result.
        if (start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with the control state so
      // an abandoned division leaves nothing behind.
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      work     <= work_d;
      divisor  <= divisor_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
//   Signed expectations depend on DIV_SIGNED_EN, matching the build of the DUT.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready, stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stall_req_o  (stall_req)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a division and wait (bounded) for ready; checks latency, stall
  // behaviour while busy, the result and that stall drops once ready.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input int lat_exp, input logic [63:0] res_exp,
                         input bit scramble);
    int lat;
    bit stall_ok;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    annul      = 1'b0;
    start      = 1'b1;
    #1;
    lat      = 0;
    stall_ok = 1'b1;
    while (!ready && lat < 40) begin
      if (!stall_req) stall_ok = 1'b0;
      step();
      lat++;
      if (scramble && lat == 3) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~signed_div;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, "_res"}, result, res_exp);
    check({tag, "_stall_end"}, 64'(stall_req), 64'd0);
  endtask

  task automatic release_div(input string tag);
    start = 1'b0;
    step();
    check({tag, "_rel_ready"}, 64'(ready), 64'd0);
    check({tag, "_rel_res"}, result, 64'd0);
  endtask

  initial begin
    logic [63:0] exp_neg7;
    logic [63:0] exp_ovf;
    bit          never_ready;
`ifdef DIV_SIGNED_EN
    exp_neg7 = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    exp_ovf  = {32'h0000_0000, 32'h8000_0000};
`else
    exp_neg7 = {32'h0000_0001, 32'h7FFF_FFFC};
    exp_ovf  = {32'h8000_0000, 32'h0000_0000};
`endif

    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_res", result, 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);

    // 100 / 7 unsigned; hold start in END and confirm the result stays put.
    run_div("u100_7", 32'd100, 32'd7, 1'b0, 34, {32'd2, 32'd14}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_res", result, {32'd2, 32'd14});
      check("hold_stall", 64'(stall_req), 64'd0);
    end
    release_div("u100_7");

    // -7 / 2 signed, then the same bits unsigned.
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 34, exp_neg7, 1'b0);
    release_div("s_m7_2");
    run_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 34, {32'h0000_0001, 32'h7FFF_FFFC}, 1'b0);
    release_div("u_m7_2");

    // Divide by zero: ready after one extra edge, result zero.
    run_div("div0", 32'd1234, 32'd0, 1'b0, 2, 64'd0, 1'b0);
    release_div("div0");

    // Annul at iteration 10: back to FREE, ready never rises.
    opdata1 = 32'd50;
    opdata2 = 32'd3;
    start   = 1'b1;
    annul   = 1'b0;
    for (int i = 0; i < 11; i++) step();
    annul = 1'b1;
    step();
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_res", result, 64'd0);
    check("annul_stall", 64'(stall_req), 64'd0);
    // annul with start in FREE must block a new division.
    never_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) never_ready = 1'b0;
    end
    check("annul_blocks", 64'(never_ready), 64'd1);
    start = 1'b0;
    annul = 1'b0;
    step();
    run_div("u20_4", 32'd20, 32'd4, 1'b0, 34, {32'd0, 32'd5}, 1'b0);
    release_div("u20_4");

    // Signed overflow case wraps without a trap.
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, exp_ovf, 1'b0);
    release_div("ovf");

    // Reset at iteration 5 discards the division.
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    start   = 1'b1;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_res", result, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    step();
    check("post_rst_ready", 64'(ready), 64'd0);
    check("post_rst_stall", 64'(stall_req), 64'd0);

    // Operands scrambled during ON must not disturb the latched division.
    run_div("scramble", 32'd9, 32'd3, 1'b0, 34, {32'd0, 32'd3}, 1'b1);
    release_div("scramble");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
